// File: rtl/servo_pwm_multi_avalon_if.sv
// Avalon-MM slave bus bundle for the multi-channel servo PWM block.
// No waitrequest: writes complete in one cycle and readdata is registered.
interface servo_pwm_multi_avalon_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;

    modport master (
        output address, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata
    );
endinterface

// File: rtl/servo_pwm_multi_avalon.sv
// Multi-channel hobby-servo PWM generator behind an Avalon-MM slave.
// One shared frame counter; positions and enables only take effect at frame boundaries.
module servo_pwm_multi_avalon #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned FRAME_TICKS = 1000000,
    parameter int unsigned MIN_TICKS   = 50000,
    parameter int unsigned STEP_TICKS  = 196,
    parameter int unsigned SLEW_STEP   = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    servo_pwm_multi_avalon_if.slave bus,
    output logic [NUM_CH-1:0]       servo_pwm,
    output logic                    frame_start
);

    localparam logic [7:0] SlewInc = 8'(SLEW_STEP);

    logic [31:0]       frame_cnt;
    logic              frame_wrap;
    logic [NUM_CH-1:0] ctrl;
    logic [NUM_CH-1:0] en_act;
    logic [7:0]        target      [NUM_CH];
    logic [7:0]        current     [NUM_CH];
    logic [7:0]        current_nxt [NUM_CH];
    logic signed [8:0] diff        [NUM_CH];
    logic [8:0]        abs_diff    [NUM_CH];
    logic [31:0]       thresh      [NUM_CH];
    logic [NUM_CH-1:0] pwm_nxt;
    logic [NUM_CH-1:0] busy;
    logic [31:0]       rdata_nxt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       addr_idx;
    logic              unused_wdata;

    assign addr         = bus.address;
    assign addr_idx     = 32'(addr);
    assign frame_wrap   = (frame_cnt == FRAME_TICKS - 1);
    assign unused_wdata = ^bus.writedata[31:8];

    // Slew toward target and build each channel's compare value from current position.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            diff[i]     = $signed({1'b0, target[i]}) - $signed({1'b0, current[i]});
            abs_diff[i] = diff[i][8] ? (9'd0 - diff[i]) : diff[i];
            if (SLEW_STEP == 0 || {23'd0, abs_diff[i]} <= SLEW_STEP) begin
                current_nxt[i] = target[i];
            end else if (diff[i][8]) begin
                current_nxt[i] = current[i] - SlewInc;
            end else begin
                current_nxt[i] = current[i] + SlewInc;
            end
            thresh[i]  = MIN_TICKS + 32'(current[i]) * STEP_TICKS;
            pwm_nxt[i] = en_act[i] && (frame_cnt < thresh[i]);
            busy[i]    = (current[i] != target[i]);
        end
    end

    always_comb begin
        rdata_nxt = '0;
        if (addr_idx == 32'd0) begin
            rdata_nxt = 32'(ctrl);
        end else if (addr_idx == 32'd1) begin
            rdata_nxt[NUM_CH-1:0] = busy;
            rdata_nxt[31]         = (en_act != ctrl);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr_idx == 32'(i) + 32'd2) begin
                    rdata_nxt = {16'd0, current[i], target[i]};
                end
            end
        end
    end

    // frame_start is registered like servo_pwm so both share the same one-cycle lag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
            servo_pwm   <= '0;
            en_act      <= '0;
        end else begin
            frame_cnt   <= frame_wrap ? 32'd0 : frame_cnt + 32'd1;
            frame_start <= (frame_cnt == 32'd0);
            servo_pwm   <= pwm_nxt;
            if (frame_wrap) begin
                en_act <= ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl         <= '0;
            bus.readdata <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                target[i]  <= '0;
                current[i] <= '0;
            end
        end else begin
            // Read mux uses pre-write state, so a same-cycle read returns the old value.
            if (bus.read) begin
                bus.readdata <= rdata_nxt;
            end
            if (bus.write && addr_idx == 32'd0) begin
                ctrl <= bus.writedata[NUM_CH-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.write && addr_idx == 32'(i) + 32'd2) begin
                    target[i] <= bus.writedata[7:0];
                end
                if (frame_wrap) begin
                    current[i] <= current_nxt[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi_avalon.sv
// Directed bench for servo_pwm_multi_avalon: table of bus ops and frame-width checks,
// plus hand sequences for same-cycle readback, disable mid-pulse, saturation and reset.
module tb_servo_pwm_multi_avalon;

    localparam int unsigned NumCh      = 2;
    localparam int unsigned AddrW      = 4;
    localparam int unsigned FrameTicks = 100;
    localparam int unsigned MinTicks   = 10;
    localparam int unsigned StepTicks  = 1;
    localparam int unsigned SlewStep   = 4;

    typedef enum logic [2:0] {OpMid, OpWr, OpRd, OpPwm, OpFrame} op_e;
    typedef struct {
        op_e         op;
        logic [3:0]  addr;
        logic [31:0] data;
        int          hi0;
        int          hi1;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NumCh-1:0] servo_pwm;
    logic             frame_start;
    int               n_checks = 0;
    int               n_pass = 0;
    vec_t             vecs[$];

    always #5 clk = ~clk;

    servo_pwm_multi_avalon_if #(.ADDR_W(AddrW)) bus_if ();

    servo_pwm_multi_avalon #(
        .NUM_CH      (NumCh),
        .ADDR_W      (AddrW),
        .FRAME_TICKS (FrameTicks),
        .MIN_TICKS   (MinTicks),
        .STEP_TICKS  (StepTicks),
        .SLEW_STEP   (SlewStep)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .servo_pwm   (servo_pwm),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string name);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (frame_start) return;
        end
        n_checks++;
        $display("FAIL %s: no frame_start within 300 cycles", name);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        tick();
        bus_if.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.address = a;
        bus_if.read    = 1'b1;
        tick();
        bus_if.read    = 1'b0;
        d = bus_if.readdata;
    endtask

    task automatic bus_wr_rd(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] d);
        @(negedge clk);
        bus_if.address   = a;
        bus_if.writedata = wd;
        bus_if.write     = 1'b1;
        bus_if.read      = 1'b1;
        tick();
        bus_if.write     = 1'b0;
        bus_if.read      = 1'b0;
        d = bus_if.readdata;
    endtask

    // Pulse width per channel as leading high samples from frame_start; -1 if not one clean pulse.
    // Optionally issues one bus write after sample wr_k.
    task automatic measure_frame(input string name, input int wr_k, input logic [3:0] wr_a,
                                 input logic [31:0] wr_d, output int w0, output int w1);
        int lead [2];
        int total [2];
        bit run [2];
        wait_fs(name);
        for (int c = 0; c < 2; c++) begin
            lead[c] = 0;
            total[c] = 0;
            run[c] = 1'b1;
        end
        for (int k = 0; k < 100; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (servo_pwm[c]) begin
                    total[c]++;
                    if (run[c]) lead[c]++;
                end else begin
                    run[c] = 1'b0;
                end
            end
            if (k == wr_k) begin
                bus_if.address   = wr_a;
                bus_if.writedata = wr_d;
                bus_if.write     = 1'b1;
            end
            if (k == wr_k + 1) bus_if.write = 1'b0;
            if (k < 99) tick();
        end
        w0 = (lead[0] == total[0]) ? lead[0] : -1;
        w1 = (lead[1] == total[1]) ? lead[1] : -1;
    endtask

    function automatic void add(input op_e op, input logic [3:0] a, input logic [31:0] d,
                                input int h0, input int h1);
        vec_t v;
        v.op = op;
        v.addr = a;
        v.data = d;
        v.hi0 = h0;
        v.hi1 = h1;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          w0;
        int          w1;
        int          cyc;
        int          cur;
        int          exp_w;

        // Slew up 0->20 by 4, then down 20->2, all on channel 0.
        add(OpMid,   4'd0, 32'd50,         0, 0);
        add(OpWr,    4'd2, 32'd20,         0, 0);
        add(OpWr,    4'd0, 32'd1,          0, 0);
        add(OpPwm,   4'd0, 32'd0,          0, 0);
        add(OpRd,    4'd1, 32'h8000_0001,  0, 0);
        add(OpFrame, 4'd0, 32'd0,         14, 0);
        add(OpFrame, 4'd0, 32'd0,         18, 0);
        add(OpFrame, 4'd0, 32'd0,         22, 0);
        add(OpFrame, 4'd0, 32'd0,         26, 0);
        add(OpFrame, 4'd0, 32'd0,         30, 0);
        add(OpFrame, 4'd0, 32'd0,         30, 0);
        add(OpRd,    4'd1, 32'h0000_0000,  0, 0);
        add(OpRd,    4'd2, 32'h0000_1414,  0, 0);
        add(OpRd,    4'd0, 32'h0000_0001,  0, 0);
        add(OpWr,    4'd2, 32'd2,          0, 0);
        add(OpFrame, 4'd0, 32'd0,         26, 0);
        add(OpFrame, 4'd0, 32'd0,         22, 0);
        add(OpFrame, 4'd0, 32'd0,         18, 0);
        add(OpFrame, 4'd0, 32'd0,         14, 0);
        add(OpFrame, 4'd0, 32'd0,         12, 0);
        add(OpFrame, 4'd0, 32'd0,         12, 0);
        add(OpRd,    4'd2, 32'h0000_0202,  0, 0);

        reset_n          = 1'b0;
        bus_if.address   = '0;
        bus_if.write     = 1'b0;
        bus_if.writedata = '0;
        bus_if.read      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_pwm", 32'(servo_pwm), 32'd0);
        check("por_rdata", bus_if.readdata, 32'd0);
        check("por_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("fs_first_clk", 32'(frame_start), 32'd1);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!frame_start && cyc < 300);
        check("fs_period", 32'(cyc), 32'd100);

        for (int i = 0; i < vecs.size(); i++) begin
            unique case (vecs[i].op)
                OpMid: begin
                    wait_fs($sformatf("vec%0d", i));
                    repeat (vecs[i].data) tick();
                end
                OpWr: bus_write(vecs[i].addr, vecs[i].data);
                OpRd: begin
                    bus_read(vecs[i].addr, rd);
                    check($sformatf("vec%0d_rd", i), rd, vecs[i].data);
                end
                OpPwm: check($sformatf("vec%0d_pwm", i), 32'(servo_pwm), vecs[i].data);
                OpFrame: begin
                    measure_frame($sformatf("vec%0d", i), -1, 4'd0, 32'd0, w0, w1);
                    check($sformatf("vec%0d_w0", i), w0, vecs[i].hi0);
                    check($sformatf("vec%0d_w1", i), w1, vecs[i].hi1);
                end
                default: ;
            endcase
        end

        // Same-cycle write+read returns the pre-write value; current follows one boundary later.
        bus_wr_rd(4'd3, 32'h0000_00A5, rd);
        check("ch1_wr_rd_same", rd, 32'h0000_0000);
        bus_read(4'd3, rd);
        check("ch1_rd_target", rd, 32'h0000_00A5);
        wait_fs("ch1_boundary");
        bus_read(4'd3, rd);
        check("ch1_rd_slewed", rd, 32'h0000_04A5);
        bus_read(4'd7, rd);
        check("unmapped_rd", rd, 32'h0000_0000);

        // Disable ch0 mid-pulse: current pulse completes, later frames stay low while slewing.
        bus_write(4'd2, 32'd30);
        measure_frame("dis_frame", 2, 4'd0, 32'd0, w0, w1);
        check("dis_full_pulse", w0, 32'd16);
        measure_frame("dis_next", -1, 4'd0, 32'd0, w0, w1);
        check("dis_next_w0", w0, 32'd0);
        check("dis_next_w1", w1, 32'd0);
        bus_read(4'd2, rd);
        check("dis_still_slews", rd, 32'h0000_0E1E);

        // Climb toward 255; width saturates at the full frame once MIN_TICKS+current >= 100.
        bus_write(4'd0, 32'd1);
        bus_write(4'd2, 32'd255);
        cur = 14;
        for (int f = 0; f < 25; f++) begin
            cur = (cur + 4 > 255) ? 255 : cur + 4;
            exp_w = (10 + cur >= 100) ? 100 : 10 + cur;
            measure_frame($sformatf("sat%0d", f), -1, 4'd0, 32'd0, w0, w1);
            check($sformatf("sat%0d_w0", f), w0, exp_w);
        end

        // Independent channels, both enabled, run to steady state.
        bus_write(4'd2, 32'd0);
        bus_write(4'd3, 32'd40);
        bus_write(4'd0, 32'd3);
        repeat (70) wait_fs("indep_settle");
        measure_frame("indep", -1, 4'd0, 32'd0, w0, w1);
        check("indep_w0", w0, 32'd10);
        check("indep_w1", w1, 32'd50);
        bus_read(4'd1, rd);
        check("indep_status", rd, 32'h0000_0000);
        bus_read(4'd3, rd);
        check("indep_ch1_rd", rd, 32'h0000_2828);

        // Asynchronous reset in the middle of a pulse.
        wait_fs("rst_frame");
        repeat (3) tick();
        check("rst_pre_pwm", 32'(servo_pwm), 32'd3);
        reset_n = 1'b0;
        #1;
        check("rst_pwm", 32'(servo_pwm), 32'd0);
        check("rst_rdata", bus_if.readdata, 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_fs_first_clk", 32'(frame_start), 32'd1);
        bus_read(4'd0, rd);
        check("rst_ctrl", rd, 32'd0);
        measure_frame("rst_next", -1, 4'd0, 32'd0, w0, w1);
        check("rst_next_w0", w0, 32'd0);
        check("rst_next_w1", w1, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
